// File: rtl/ltc1668_dac_driver.sv
// ltc1668_dac_driver: output stage between the NCO and the LTC1668 DAC.
// Holds the latest sample, applies ramped gain, offset and saturation,
// converts to offset binary and presents it on a divided, registered
// DAC update clock. A soft-mute ramp avoids output steps.
module ltc1668_dac_driver #(
   parameter int UPDATE_DIV = 4,
   parameter int RAMP_STEP  = 8
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        in_valid,
   input  logic [15:0] in_data,
   input  logic [7:0]  gain,
   input  logic [15:0] offset,
   input  logic        mute,
   input  logic        clip_clr,
   output logic [15:0] dac_data,
   output logic        dac_clk,
   output logic        muted,
   output logic        clip
);

   localparam int DATA_W = 16;
   localparam int COEF_W = 8;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int SUM_W  = DATA_W + 2;
   localparam int CNT_W  = $clog2(UPDATE_DIV);

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(UPDATE_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(UPDATE_DIV / 2);
   localparam logic [7:0]       RAMP_FULL = 8'd128;
   localparam logic [7:0]       STEP8     = 8'(RAMP_STEP);
   localparam logic signed [SUM_W-1:0] SAT_MAX = 18'sd32767;
   localparam logic signed [SUM_W-1:0] SAT_MIN = -18'sd32768;

   typedef enum logic [1:0] {
      ST_MUTED,
      ST_RAMP_UP,
      ST_RUN,
      ST_RAMP_DOWN
   } state_t;

   // Clamp an 18-bit sum to the 16-bit signed range.
   function automatic logic signed [DATA_W-1:0] sat16(input logic signed [SUM_W-1:0] v);
      if (v > SAT_MAX) begin
         return 16'sh7FFF;
      end else if (v < SAT_MIN) begin
         return 16'sh8000;
      end
      return v[DATA_W-1:0];
   endfunction

   // True when the 18-bit sum lies outside the 16-bit signed range.
   function automatic logic ovf16(input logic signed [SUM_W-1:0] v);
      return (v > SAT_MAX) || (v < SAT_MIN);
   endfunction

   state_t                     state_q, state_d;
   logic [7:0]                 ramp_q, ramp_d;
   logic [7:0]                 ramp_up_lvl, ramp_dn_lvl;
   logic [8:0]                 ramp_inc;
   logic [CNT_W-1:0]           cnt_q, cnt_d;
   logic                       wrap;
   logic                       dac_clk_q, dac_clk_d;
   logic signed [DATA_W-1:0]   hold_p0_q, hold_p0_d;
   logic [COEF_W-1:0]          eff_p0_q, eff_p0_d;
   logic [15:0]                gain_ramp;
   logic signed [PROD_W-1:0]   hold_ext, eff_ext;
   logic signed [PROD_W-1:0]   prod_p1_q, prod_p1_d;
   logic signed [SUM_W-1:0]    sum_w;
   logic signed [DATA_W-1:0]   sum_p2_q, sum_p2_d;
   logic                       clip_q, clip_d;
   logic [DATA_W-1:0]          dac_data_q, dac_data_d;

   assign wrap     = (cnt_q == CNT_LAST);
   assign dac_data = dac_data_q;
   assign dac_clk  = dac_clk_q;
   assign muted    = (state_q == ST_MUTED);
   assign clip     = clip_q;

   // Candidate ramp levels one step up / down, saturated at 128 and 0.
   always_comb begin
      ramp_inc    = {1'b0, ramp_q} + {1'b0, STEP8};
      ramp_up_lvl = (ramp_inc >= 9'd128) ? RAMP_FULL : ramp_inc[7:0];
      ramp_dn_lvl = (ramp_q <= STEP8) ? 8'd0 : (ramp_q - STEP8);
   end

   // Soft-mute next state: steps are taken only on wrap edges, and a change
   // of direction applies its first step on the same edge.
   always_comb begin
      state_d = state_q;
      ramp_d  = ramp_q;
      if (wrap) begin
         case (state_q)
            ST_MUTED: begin
               if (!mute) begin
                  ramp_d  = ramp_up_lvl;
                  state_d = (ramp_up_lvl == RAMP_FULL) ? ST_RUN : ST_RAMP_UP;
               end else begin
                  ramp_d  = 8'd0;
               end
            end
            ST_RAMP_UP, ST_RAMP_DOWN: begin
               if (mute) begin
                  ramp_d  = ramp_dn_lvl;
                  state_d = (ramp_dn_lvl == 8'd0) ? ST_MUTED : ST_RAMP_DOWN;
               end else begin
                  ramp_d  = ramp_up_lvl;
                  state_d = (ramp_up_lvl == RAMP_FULL) ? ST_RUN : ST_RAMP_UP;
               end
            end
            ST_RUN: begin
               if (mute) begin
                  ramp_d  = ramp_dn_lvl;
                  state_d = (ramp_dn_lvl == 8'd0) ? ST_MUTED : ST_RAMP_DOWN;
               end else begin
                  ramp_d  = RAMP_FULL;
               end
            end
            default: begin
               state_d = ST_MUTED;
               ramp_d  = 8'd0;
            end
         endcase
      end
   end

   // Soft-mute state and ramp level registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= ST_MUTED;
         ramp_q  <= 8'd0;
      end else begin
         state_q <= state_d;
         ramp_q  <= ramp_d;
      end
   end

   // Divider, datapath stages, clip flag and DAC output next values.
   always_comb begin
      cnt_d     = wrap ? '0 : (cnt_q + CNT_W'(1));
      dac_clk_d = (cnt_d >= CNT_HALF);

      // p0: sample hold and effective gain
      hold_p0_d = in_valid ? in_data : hold_p0_q;
      gain_ramp = {8'd0, gain} * {8'd0, ramp_q};
      eff_p0_d  = COEF_W'(gain_ramp >> 7);

      // p1: signed 16 x unsigned 8 product
      hold_ext  = {{(PROD_W - DATA_W){hold_p0_q[DATA_W-1]}}, hold_p0_q};
      eff_ext   = {{(PROD_W - COEF_W){1'b0}}, eff_p0_q};
      prod_p1_d = hold_ext * eff_ext;

      // p2: rescale, add offset, saturate
      sum_w     = SUM_W'(prod_p1_q >>> 7) + {{(SUM_W - DATA_W){offset[DATA_W-1]}}, offset};
      sum_p2_d  = sat16(sum_w);
      clip_d    = ovf16(sum_w) ? 1'b1 : (clip_clr ? 1'b0 : clip_q);

      // out: offset-binary code, updated only on wrap edges
      dac_data_d = wrap ? (sum_p2_q ^ 16'h8000) : dac_data_q;
   end

   // Divider, pipeline and output registers; reset discards in-flight data.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q      <= '0;
         dac_clk_q  <= 1'b0;
         hold_p0_q  <= '0;
         eff_p0_q   <= '0;
         prod_p1_q  <= '0;
         sum_p2_q   <= '0;
         clip_q     <= 1'b0;
         dac_data_q <= 16'h8000;
      end else begin
         cnt_q      <= cnt_d;
         dac_clk_q  <= dac_clk_d;
         hold_p0_q  <= hold_p0_d;
         eff_p0_q   <= eff_p0_d;
         prod_p1_q  <= prod_p1_d;
         sum_p2_q   <= sum_p2_d;
         clip_q     <= clip_d;
         dac_data_q <= dac_data_d;
      end
   end

endmodule

// File: tb/tb_ltc1668_dac_driver.sv
// Bench for ltc1668_dac_driver: two instances (UPDATE_DIV=4/RAMP_STEP=16 and
// UPDATE_DIV=6/RAMP_STEP=8) share one directed stimulus; an edge-indexed
// history model predicts every output each cycle, and hand-computed
// literals pin the model at the key points.
module tb_ltc1668_dac_driver;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        in_valid;
   logic [15:0] in_data;
   logic [7:0]  gain;
   logic [15:0] offset;
   logic        mute;
   logic        clip_clr;

   logic [15:0] dac_data_a, dac_data_b;
   logic        dac_clk_a, dac_clk_b;
   logic        muted_a, muted_b;
   logic        clip_a, clip_b;

   int errors = 0;
   int checks = 0;
   int k = 0;

   always #5 clk = ~clk;

   ltc1668_dac_driver #(.UPDATE_DIV(4), .RAMP_STEP(16)) dut_a (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .gain(gain), .offset(offset), .mute(mute), .clip_clr(clip_clr),
      .dac_data(dac_data_a), .dac_clk(dac_clk_a), .muted(muted_a), .clip(clip_a)
   );

   ltc1668_dac_driver #(.UPDATE_DIV(6), .RAMP_STEP(8)) dut_b (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
      .gain(gain), .offset(offset), .mute(mute), .clip_clr(clip_clr),
      .dac_data(dac_data_b), .dac_clk(dac_clk_b), .muted(muted_b), .clip(clip_b)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at k=%0d: got %0h expected %0h", name, k, act, exp);
      end
   endtask

   function automatic int div_of(input int i);
      return (i == 0) ? 4 : 6;
   endfunction

   function automatic int step_of(input int i);
      return (i == 0) ? 16 : 8;
   endfunction

   // Model: values after each clock edge e, indexed by edge number.
   int          e = 0;
   bit          mvalid = 1'b0;
   bit          rst_h  [0:4095];
   int          hold_h [2][0:4095];
   int          eff_h  [2][0:4095];
   int          s2_h   [2][0:4095];
   int          m_n    [2];
   int          m_ramp [2];
   logic        m_clip [2];
   logic [15:0] m_dac  [2];
   int          ramp_prev, prod_m, sum_m, s2_m;
   logic [31:0] s2_bits;

   always @(posedge clk) begin
      e = e + 1;
      for (int i = 0; i < 2; i++) begin
         if (!reset_n) begin
            m_n[i]       = 0;
            m_ramp[i]    = 0;
            m_clip[i]    = 1'b0;
            m_dac[i]     = 16'h8000;
            hold_h[i][e] = 0;
            eff_h[i][e]  = 0;
            s2_h[i][e]   = 0;
         end else begin
            ramp_prev    = m_ramp[i];
            m_n[i]       = m_n[i] + 1;
            hold_h[i][e] = in_valid ? int'($signed(in_data)) : hold_h[i][e-1];
            eff_h[i][e]  = (int'(gain) * ramp_prev) / 128;
            prod_m       = rst_h[e-1] ? 0 : ((hold_h[i][e-2] * eff_h[i][e-2]) >>> 7);
            sum_m        = prod_m + int'($signed(offset));
            s2_m         = (sum_m > 32767) ? 32767 : ((sum_m < -32768) ? -32768 : sum_m);
            s2_h[i][e]   = s2_m;
            if (sum_m != s2_m) m_clip[i] = 1'b1;
            else if (clip_clr) m_clip[i] = 1'b0;
            if ((m_n[i] % div_of(i)) == 0) begin
               s2_bits  = s2_h[i][e-1];
               m_dac[i] = s2_bits[15:0] ^ 16'h8000;
               if (mute) m_ramp[i] = (m_ramp[i] - step_of(i) < 0) ? 0 : m_ramp[i] - step_of(i);
               else      m_ramp[i] = (m_ramp[i] + step_of(i) > 128) ? 128 : m_ramp[i] + step_of(i);
            end
         end
      end
      rst_h[e] = !reset_n;
      mvalid   = 1'b1;
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (mvalid) begin
         chk("dac_data_a", dac_data_a, m_dac[0]);
         chk("dac_clk_a", dac_clk_a, (m_n[0] % 4) >= 2);
         chk("muted_a", muted_a, m_ramp[0] == 0);
         chk("clip_a", clip_a, m_clip[0]);
         chk("dac_data_b", dac_data_b, m_dac[1]);
         chk("dac_clk_b", dac_clk_b, (m_n[1] % 6) >= 3);
         chk("muted_b", muted_b, m_ramp[1] == 0);
         chk("clip_b", clip_b, m_clip[1]);
      end
   end

   task automatic cyc();
      @(negedge clk);
      k++;
   endtask

   task automatic run_to(input int kk);
      while (k < kk) cyc();
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int          prev_a;
      logic [15:0] prev_b;
      logic [15:0] exp_b;
      logic [31:0] ramp_val;
      bit          pat [6];
      pat = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      // Reset with random inputs
      reset_n = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'($urandom);
         in_data  = 16'($urandom);
         gain     = 8'($urandom);
         offset   = 16'($urandom);
         mute     = 1'($urandom);
         clip_clr = 1'($urandom);
         @(negedge clk);
      end
      chk("rst_dac_a", dac_data_a, 16'h8000);
      chk("rst_clk_a", dac_clk_a, 1'b0);
      chk("rst_muted_a", muted_a, 1'b1);
      chk("rst_clip_a", clip_a, 1'b0);
      chk("rst_dac_b", dac_data_b, 16'h8000);

      // Release, unmute, unity gain
      reset_n = 1'b1; mute = 1'b0; gain = 8'h80; offset = 16'h0000;
      in_valid = 1'b1; in_data = 16'h4000; clip_clr = 1'b0;
      run_to(3);   chk("lit_muted_a_k3", muted_a, 1'b1);
      run_to(4);   chk("lit_muted_a_k4", muted_a, 1'b0);
      run_to(5);   chk("lit_muted_b_k5", muted_b, 1'b1);
      run_to(6);   chk("lit_muted_b_k6", muted_b, 1'b0);
      run_to(96);  chk("lit_ramp120_b", dac_data_b, 16'hBC00);
                   chk("lit_run_a", dac_data_a, 16'hC000);
      run_to(102); chk("lit_run_b", dac_data_b, 16'hC000);

      // Unity passthrough and latency
      run_to(108); in_data = 16'h8000;
      run_to(111); chk("lit_lat_a_old", dac_data_a, 16'hC000);
      run_to(112); chk("lit_lat_a_new", dac_data_a, 16'h0000);
      run_to(113); chk("lit_lat_b_old", dac_data_b, 16'hC000);
      run_to(114); chk("lit_lat_b_new", dac_data_b, 16'h0000);
      run_to(120); in_data = 16'h7FFF;
      run_to(132); chk("lit_max_a", dac_data_a, 16'hFFFF);
                   chk("lit_max_b", dac_data_b, 16'hFFFF);
                   chk("lit_noclip", clip_a, 1'b0);

      // Gain and saturation
      gain = 8'hFF; in_data = 16'h7000;
      run_to(144); chk("lit_sat_a", dac_data_a, 16'hFFFF);
                   chk("lit_sat_b", dac_data_b, 16'hFFFF);
                   chk("lit_clip_set", clip_a, 1'b1);
      gain = 8'h40;
      run_to(156); chk("lit_clip_sticky", clip_b, 1'b1);
                   chk("lit_half_a", dac_data_a, 16'hB800);
                   chk("lit_half_b", dac_data_b, 16'hB800);
      clip_clr = 1'b1;
      run_to(157); clip_clr = 1'b0;
      run_to(158); chk("lit_clip_clr", clip_a, 1'b0);
      gain = 8'hFF; clip_clr = 1'b1;
      run_to(170); chk("lit_sat_wins", clip_a, 1'b1);
      gain = 8'h80;
      run_to(180); chk("lit_clr_held", clip_b, 1'b0);
                   chk("lit_7000_a", dac_data_a, 16'hF000);
      clip_clr = 1'b0;

      // Offset
      in_data = 16'hFF9C; offset = 16'd1000;
      run_to(192); chk("lit_offset_a", dac_data_a, 16'h8384);
                   chk("lit_offset_b", dac_data_b, 16'h8384);
      offset = 16'h7FFF; in_data = 16'h0100;
      run_to(204); chk("lit_off_sat", dac_data_a, 16'hFFFF);
                   chk("lit_off_clip", clip_a, 1'b1);
      offset = 16'h0000; in_data = 16'h4000;
      run_to(210); clip_clr = 1'b1;
      run_to(211); clip_clr = 1'b0;
      run_to(216); chk("lit_back_a", dac_data_a, 16'hC000);
                   chk("lit_back_clip", clip_a, 1'b0);

      // Mute ramp down, then back up
      mute = 1'b1;
      run_to(247); chk("lit_mdown_a_k247", muted_a, 1'b0);
      run_to(248); chk("lit_mdown_a_k248", muted_a, 1'b1);
                   chk("lit_ramp16_a", dac_data_a, 16'h8800);
      run_to(252); chk("lit_mid_a", dac_data_a, 16'h8000);
      run_to(311); chk("lit_mdown_b_k311", muted_b, 1'b0);
      run_to(312); chk("lit_mdown_b_k312", muted_b, 1'b1);
      run_to(320); mute = 1'b0;
      run_to(420); mute = 1'b1;
      prev_a = int'(dac_data_a);
      while (k < 460) begin
         cyc();
         if (k == 436) mute = 1'b0;
         if (k % 4 == 0) begin
            chk("jump_a", ((int'(dac_data_a) - prev_a) > 2048) || ((prev_a - int'(dac_data_a)) > 2048), 1'b0);
            prev_a = int'(dac_data_a);
         end
         if (k == 440) chk("lit_rev64_a", dac_data_a, 16'hA000);
         if (k == 444) chk("lit_rev80_a", dac_data_a, 16'hA800);
         if (k == 456) chk("lit_rerun_a", dac_data_a, 16'hC000);
      end

      // Update clock with ramp input every cycle
      run_to(462);
      prev_b = dac_data_b;
      while (k < 492) begin
         ramp_val = 32'(k * 37);
         in_data  = ramp_val[15:0];
         cyc();
         chk("pat_clk_b", dac_clk_b, pat[k % 6]);
         if (k % 6 == 0 && k >= 468) begin
            ramp_val = 32'((k - 4) * 37);
            exp_b    = ramp_val[15:0] ^ 16'h8000;
            chk("lit_decim_b", dac_data_b, exp_b);
         end else if (k % 6 != 0) begin
            chk("hold_b", dac_data_b, prev_b);
         end
         prev_b = dac_data_b;
      end

      run_to(500);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ltc1668_dac_driver.md
# ltc1668_dac_driver

Output stage between the NCO and the LTC1668 16-bit parallel DAC on the DE0-Nano. It does four things:
- Holds the latest valid signed sine sample from the NCO.
- Applies programmable gain, offset and saturation.
- Converts the result to the DAC's offset-binary code.
- Presents the code to the DAC at a fixed divided update rate, with a matching registered DAC clock.

A soft-mute ramp state machine keeps the DAC output free of steps on mute, unmute and power-up.

## Interface
Parameters:
- UPDATE_DIV, 4: clk cycles per DAC update. Even, ≥ 4.
- RAMP_STEP, 8: ramp-level increment/decrement per DAC update. Range 1..128.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, synchronous, active-low
- in_valid  in  1  NCO sample strobe (may be high every cycle)
- in_data  in  16  signed two's-complement sample
- gain  in  8  unsigned amplitude, 0x80 = unity (Q1.7)
- offset  in  16  signed offset added after gain
- mute  in  1  level request: 1 = ramp to silence, 0 = ramp to full
- clip_clr  in  1  clears the clip flag
- dac_data  out  16  offset-binary DAC code
- dac_clk  out  1  DAC latch clock; the DAC samples on its rising edge
- muted  out  1  high only in state MUTED
- clip  out  1  sticky saturation flag

## Operation
- **Hold register (hold):** loads in_data on any edge with in_valid=1. Otherwise it keeps its value. Reset value 0.
- **Divider (cnt):** counts 0..UPDATE_DIV-1 and wraps. A "wrap edge" is the edge that sets cnt to 0. All DAC updates and all ramp steps occur on wrap edges.
- **Ramp level (ramp):** 8-bit, range 0..128.
- **Effective gain (eff):** eff = (gain*ramp)>>7, registered every edge, range 0..255.
- **Datapath:** runs every edge and is free-running.
  - S1: prod = hold * eff. Signed 16 × unsigned 8 (treated as signed 9) gives a 25-bit signed result.
  - S2: sum = (prod >>> 7) + sign-extended offset, computed at 18 bits. Saturate to [-32768, 32767]. If saturation occurs, set clip.
  - Out: on a wrap edge, dac_data = S2 ^ 0x8000.
- **clip:** sticky. clip_clr=1 clears it. If clip_clr and a new saturation coincide on the same edge, saturation wins and clip stays 1.
- **State machine:** ramp steps occur only on wrap edges. Step results saturate at 0 and 128.
  - MUTED: ramp=0. If !mute, go to RAMP_UP.
  - RAMP_UP: ramp += RAMP_STEP. When ramp reaches 128, go to RUN. If mute=1, go to RAMP_DOWN, starting from the current level.
  - RUN: ramp=128. If mute=1, go to RAMP_DOWN.
  - RAMP_DOWN: ramp -= RAMP_STEP. When ramp reaches 0, go to MUTED. If mute=0, go to RAMP_UP, starting from the current level.
  - The state itself changes on the wrap edge that applies the step.
- In MUTED, eff=0, so dac_data settles to offset ^ 0x8000. With offset=0 this is midscale 0x8000.

## Timing
- **Reset:** every edge with reset_n=0 gives:
  - cnt=0, dac_data=0x8000, dac_clk=0
  - state MUTED, ramp=0, muted=1, clip=0
  - hold=0, eff=0, pipeline registers 0
  
  A reset mid-ramp or mid-period is immediate and discards any in-flight sample.
- **dac_clk:** registered. dac_clk=1 exactly while cnt ≥ UPDATE_DIV/2. With UPDATE_DIV=4 the per-edge pattern is 0,0,1,1.
  - dac_data changes only on wrap edges, i.e. when dac_clk goes 1→0.
  - This gives UPDATE_DIV/2 cycles of setup before the rising edge and UPDATE_DIV/2 cycles of hold after it.
- **Sample latency:** a sample captured in hold at edge k reaches S2 at edge k+2. It appears on dac_data at the first wrap edge ≥ k+3.
  - Samples arriving faster than the update rate are decimated: only the latest held value is used.
- **Gain/ramp latency:** a change to gain or ramp registers into eff one edge later. It reaches dac_data at the first wrap edge ≥ 3 edges after the change.
- **Ramp duration:** a full ramp takes ceil(128/RAMP_STEP) updates, i.e. that count × UPDATE_DIV clk cycles.
- **muted:** changes on the same wrap edge as the state.
- **Mute toggling:** mute toggling between wrap edges has no effect. Only the level sampled on a wrap edge counts.

## Test plan
1. **Reset.** Hold reset_n=0 for 3 cycles with random inputs → dac_data=0x8000, dac_clk=0, muted=1, clip=0. Then release with mute=0, RAMP_STEP=8 → muted falls on the first wrap edge, and RUN is reached after 16 updates.
2. **Unity passthrough.** In RUN with gain=0x80, offset=0:
   - in_data=0x4000 → dac_data=0xC000.
   - in_data=0x8000 → 0x0000.
   - in_data=0x7FFF → 0xFFFF.
   - Each change appears at the first wrap edge ≥ 3 edges after in_valid.
3. **Gain and saturation.** gain=0xFF, in_data=0x7000 (28672×255>>7=57120) → dac_data=0xFFFF and clip=1. clip stays 1 until a clip_clr pulse. Then, with gain=0x40, in_data=0x7000 → 0xB800.
4. **Offset.** gain=0x80, in_data=0xFF9C (−100), offset=1000 → dac_data=0x8384. Then offset=0x7FFF, in_data=0x0100 → 0xFFFF with clip=1.
5. **Mute ramp.** UPDATE_DIV=4, RAMP_STEP=16, in RUN:
   - Assert mute → ramp steps 112, 96, … once per 4 cycles. muted=1 after 8 updates, and dac_data=0x8000 with offset=0.
   - Repeat, but deassert mute when ramp=64 → RAMP_UP from 64, RUN after 4 updates, and no sample jumps by more than RAMP_STEP×|in|/128.
6. **Update clock.** UPDATE_DIV=6 with in_valid every cycle on a ramp input → dac_clk pattern is 0,0,0,1,1,1. dac_data changes only on 1→0 edges and equals the hold value captured ≥ 3 edges before each wrap edge.
